// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings,
// default bit timing and the byte width.
package uart_pkg;

    localparam int CLOCKS_PER_BIT = 217;
    localparam int BYTE_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } arb_state_t;

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping from the top index back to zero.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // One spare bit so rr_ptr + offset can exceed NUM_REQ-1 before folding.
    logic [IDX_W:0]   sum_idx  [NUM_REQ];
    logic [IDX_W:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rotate
            assign sum_idx[gi]  = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum_idx[gi] >= (IDX_W+1)'(NUM_REQ))
                                ? sum_idx[gi] - (IDX_W+1)'(NUM_REQ)
                                : sum_idx[gi];
            assign rot_req[gi]  = req[cand_idx[gi][IDX_W-1:0]];
        end
    endgenerate

    assign any_req = |req;

    // Scan from the far end so the lowest rotated offset wins.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                winner = cand_idx[k][IDX_W-1:0];
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// requesters, with a start timeout and an enforced inter-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CLOCKS    = CLOCKS_PER_BIT,
    parameter int START_TIMEOUT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        tx_start,
    output logic [BYTE_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CLOCKS + 1);
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);

    arb_state_t         state_reg,   state_next;
    logic [IDX_W-1:0]   rr_ptr_reg,  rr_ptr_next;
    logic [IDX_W-1:0]   grant_reg,   grant_next;
    logic [BYTE_W-1:0]  data_reg,    data_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [TO_W-1:0]    to_cnt_reg,  to_cnt_next;

    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic [BYTE_W-1:0]  req_bytes [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lanes
            assign req_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
            assign ack[gi]       = (state_reg == ST_START) && (grant_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            rr_ptr_reg  <= '0;
            grant_reg   <= '0;
            data_reg    <= '0;
            gap_cnt_reg <= '0;
            to_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            grant_reg   <= grant_next;
            data_reg    <= data_next;
            gap_cnt_reg <= gap_cnt_next;
            to_cnt_reg  <= to_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        grant_next   = grant_reg;
        data_next    = data_reg;
        gap_cnt_next = gap_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        tx_start     = 1'b0;
        err          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next  = ST_START;
                    grant_next  = winner;
                    data_next   = req_bytes[winner];
                    rr_ptr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
                end
            end

            ST_START: begin
                tx_start    = 1'b1;
                to_cnt_next = '0;
                state_next  = ST_WAIT_BUSY;
            end

            // The timeout counter tallies completed idle WAIT_BUSY cycles.
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (to_cnt_reg == TO_W'(START_TIMEOUT - 1)) begin
                    err          = 1'b1;
                    gap_cnt_next = '0;
                    state_next   = ST_GAP;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_cnt_next = '0;
                    state_next   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt_reg >= GAP_W'(GAP_CLOCKS - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign tx_data  = data_reg;
    assign grant_id = grant_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a round-robin reference model
// and a simple transmitter that holds tx_busy for busy_len clocks per frame.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 217;
    localparam int TO  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     ack;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic [1:0]       grant_id;
    logic             busy;
    logic             err;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int busy_len  = 10;
    int model_ptr = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .GAP_CLOCKS    (GAP),
        .START_TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: on each tx_start, raise tx_busy for busy_len clocks (0 = never).
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && busy_len > 0) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input logic [8*N-1:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic wait_start(input int limit, output bit found, output int stray_ack);
        int n;
        n = 0;
        found = 1'b0;
        stray_ack = 0;
        while (n < limit && !found) begin
            @(negedge clk);
            n++;
            if (tx_start === 1'b1) found = 1'b1;
            else if (ack !== '0) stray_ack++;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < 2000 && !ok) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_reset();
        bit ok;
        req = '1;
        req_data = $urandom;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, tx_start, err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0", {ack, tx_start, err, busy});
        end
        checks++;
        if ({grant_id, tx_data} !== '0) begin
            errors++;
            $display("FAIL reset_data got grant=%0d data=%h exp 0/00", grant_id, tx_data);
        end
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || ack !== 4'b0001 || grant_id !== 2'd0 || tx_data !== byte_of(req_data, 0)) begin
            errors++;
            $display("FAIL first_grant got start=%b ack=%b grant=%0d data=%h exp 1/0001/0/%h",
                     tx_start, ack, grant_id, tx_data, byte_of(req_data, 0));
        end
        $display("txn reset grant=%0d data=%h", grant_id, tx_data);
        model_ptr = 1;
        req = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_idle timeout"); end
    endtask

    task automatic test_rotation();
        bit ok;
        int stray, exp, prev;
        req = '0;
        busy_len = 10;
        do_reset(2);
        req = '1;
        req_data = $urandom;
        prev = -1;
        for (int f = 0; f < 5; f++) begin
            wait_start(400, ok, stray);
            checks++;
            if (!ok || stray != 0) begin
                errors++;
                $display("FAIL rot_start frame=%0d found=%0d stray_ack=%0d", f, ok, stray);
            end
            exp = model_pick(req);
            checks++;
            if (grant_id !== 2'(exp) || ack !== onehot(exp) || tx_data !== byte_of(req_data, exp) || exp != f % N) begin
                errors++;
                $display("FAIL rot_grant frame=%0d got grant=%0d ack=%b data=%h exp %0d/%b/%h",
                         f, grant_id, ack, tx_data, exp, onehot(exp), byte_of(req_data, exp));
            end
            if (prev >= 0) begin
                checks++;
                if (cyc - prev < 10 + GAP) begin
                    errors++;
                    $display("FAIL rot_spacing got=%0d exp>=%0d", cyc - prev, 10 + GAP);
                end
            end
            $display("txn rotation grant=%0d data=%h", grant_id, tx_data);
            prev = cyc;
            model_ptr = (exp + 1) % N;
            req_data = $urandom;
        end
        req = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rot_idle timeout"); end
    endtask

    task automatic test_timeout();
        bit ok;
        int stray, exp, t0, i;
        busy_len = 0;
        i = $urandom_range(0, N - 1);
        req = onehot(i);
        req_data = $urandom;
        wait_start(50, ok, stray);
        exp = model_pick(req);
        checks++;
        if (!ok || grant_id !== 2'(exp) || tx_data !== byte_of(req_data, exp)) begin
            errors++;
            $display("FAIL to_grant found=%0d grant=%0d exp=%0d", ok, grant_id, exp);
        end
        model_ptr = (exp + 1) % N;
        t0 = cyc;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            checks++;
            if (err !== (k == TO)) begin
                errors++;
                $display("FAIL to_err clk=%0d got=%b exp=%0d", k, err, (k == TO));
            end
        end
        wait_start(GAP + 20, ok, stray);
        checks++;
        if (!ok || stray != 0 || cyc - t0 != TO + GAP + 2) begin
            errors++;
            $display("FAIL to_regrant found=%0d stray_ack=%0d delta=%0d exp=%0d",
                     ok, stray, cyc - t0, TO + GAP + 2);
        end
        exp = model_pick(req);
        checks++;
        if (grant_id !== 2'(exp)) begin
            errors++;
            $display("FAIL to_grant2 got=%0d exp=%0d", grant_id, exp);
        end
        $display("txn timeout grant=%0d delta=%0d", grant_id, cyc - t0);
        model_ptr = (exp + 1) % N;
        req = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_idle timeout"); end
        busy_len = 10;
    endtask

    task automatic test_mid_reset();
        bit ok;
        int stray, exp;
        busy_len = 10;
        req = onehot($urandom_range(0, N - 1));
        req_data = $urandom;
        wait_start(50, ok, stray);
        exp = model_pick(req);
        checks++;
        if (!ok || grant_id !== 2'(exp)) begin
            errors++;
            $display("FAIL mr_grant found=%0d got=%0d exp=%0d", ok, grant_id, exp);
        end
        req = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy got=%b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, tx_start, err, busy, grant_id, tx_data} !== '0) begin
            errors++;
            $display("FAIL mr_async got ack=%b start=%b err=%b busy=%b grant=%0d data=%h exp all 0",
                     ack, tx_start, err, busy, grant_id, tx_data);
        end
        repeat (15) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        req = 4'b0100;
        req_data = $urandom;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || ack !== 4'b0100 || grant_id !== 2'd2 || tx_data !== byte_of(req_data, 2)) begin
            errors++;
            $display("FAIL mr_regrant got start=%b ack=%b grant=%0d data=%h exp 1/0100/2/%h",
                     tx_start, ack, grant_id, tx_data, byte_of(req_data, 2));
        end
        $display("txn mid_reset grant=%0d data=%h", grant_id, tx_data);
        model_ptr = 3;
        req = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mr_idle timeout"); end
    endtask

    task automatic test_wrap();
        bit ok;
        int stray;
        req = 4'b0011;
        req_data = $urandom;
        for (int f = 0; f < 2; f++) begin
            wait_start(400, ok, stray);
            checks++;
            if (!ok || grant_id !== 2'(f) || ack !== onehot(f) || tx_data !== byte_of(req_data, f)) begin
                errors++;
                $display("FAIL wrap_grant step=%0d found=%0d got=%0d exp=%0d", f, ok, grant_id, f);
            end
            $display("txn wrap grant=%0d data=%h", grant_id, tx_data);
            model_ptr = f + 1;
        end
        req = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_idle timeout"); end
    endtask

    task automatic test_data_hold();
        bit ok;
        int stray, exp;
        logic [7:0] held;
        busy_len = 12;
        req = onehot($urandom_range(0, N - 1));
        req_data = $urandom;
        wait_start(50, ok, stray);
        exp = model_pick(req);
        held = byte_of(req_data, exp);
        model_ptr = (exp + 1) % N;
        req = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            req_data = $urandom;
            @(negedge clk);
            checks++;
            if (tx_data !== held || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_data step=%0d got=%h busy=%b exp=%h", k, tx_data, busy, held);
            end
        end
        $display("txn data_hold grant=%0d data=%h", grant_id, held);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_idle timeout"); end
        busy_len = 10;
    endtask

    task automatic test_random();
        bit ok;
        int stray, exp;
        for (int t = 0; t < 12; t++) begin
            busy_len = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15);
            req = N'($urandom_range(1, (1 << N) - 1));
            req_data = $urandom;
            wait_start(600, ok, stray);
            exp = model_pick(req);
            checks++;
            if (!ok || stray != 0 || grant_id !== 2'(exp) || ack !== onehot(exp) || tx_data !== byte_of(req_data, exp)) begin
                errors++;
                $display("FAIL rand_grant t=%0d req=%b found=%0d got grant=%0d ack=%b data=%h exp %0d/%b/%h",
                         t, req, ok, grant_id, ack, tx_data, exp, onehot(exp), byte_of(req_data, exp));
            end
            $display("txn random req=%b grant=%0d data=%h busy_len=%0d", req, grant_id, tx_data, busy_len);
            model_ptr = (exp + 1) % N;
        end
        req = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rand_idle timeout"); end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        req_data = '0;
        test_reset();
        test_rotation();
        test_timeout();
        test_mid_reset();
        test_wrap();
        test_data_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
